// File: rtl/vga_pkg.sv
// Package: vga_pkg
// Default 640x480@60 Hz raster timing and the shared counter width.
// The top module uses these as parameter defaults and derives its own
// totals and active-window bounds from whatever parameters it receives.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_H_ACT  = 640;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 29;
    localparam int DEF_V_ACT  = 480;
    localparam int DEF_V_FP   = 10;

    localparam int DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_ACT + DEF_H_FP;  // 800
    localparam int DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_ACT + DEF_V_FP;  // 521
    localparam int DEF_H_START = DEF_H_SYNC + DEF_H_BP;                         // 144
    localparam int DEF_H_END   = DEF_H_START + DEF_H_ACT;                       // 784
    localparam int DEF_V_START = DEF_V_SYNC + DEF_V_BP;                         // 31
    localparam int DEF_V_END   = DEF_V_START + DEF_V_ACT;                       // 511

endpackage

// File: rtl/pixel_tick_gen.sv
// Module: pixel_tick_gen
// Divides the board clock to the pixel rate as a clock-enable strobe.
// Ports:
//   clk    - board clock
//   rst_n  - asynchronous active-low reset
//   pix_en - registered strobe, high for one clk when the divider is at CLK_DIV-1
module pixel_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;

    assign div_nxt = (div == DIV_LAST) ? '0 : div + 1'b1;

    // pix_en is decoded from the next divider value so it is high exactly
    // while the divider sits at its last count; with CLK_DIV=1 this makes it
    // a constant 1 from the first clk after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div    <= '0;
            pix_en <= 1'b0;
        end else begin
            div    <= div_nxt;
            pix_en <= (div_nxt == DIV_LAST);
        end
    end

endmodule

// File: rtl/vga_timing_controller.sv
// Module: vga_timing_controller
// VGA raster timing generator (640x480@60 Hz by default).
// Ports:
//   clk         - board clock
//   rst_n       - asynchronous active-low reset
//   leds_in     - live LED/switch vector
//   hcount      - horizontal pixel position, 0..H_TOTAL-1
//   vcount      - vertical line position, 0..V_TOTAL-1
//   hsync       - active-low horizontal sync
//   vsync       - active-low vertical sync
//   bright      - high inside the active picture region
//   pix_en      - one-clk strobe per pixel
//   frame_start - one-pixel pulse when the raster wraps to (0,0)
//   leds_frame  - leds_in as latched at the most recent frame wrap
module vga_timing_controller
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int H_SYNC  = DEF_H_SYNC,
    parameter int H_BP    = DEF_H_BP,
    parameter int H_ACT   = DEF_H_ACT,
    parameter int H_FP    = DEF_H_FP,
    parameter int V_SYNC  = DEF_V_SYNC,
    parameter int V_BP    = DEF_V_BP,
    parameter int V_ACT   = DEF_V_ACT,
    parameter int V_FP    = DEF_V_FP,
    parameter int LED_W   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LED_W-1:0] leds_in,
    output logic [9:0]       hcount,
    output logic [9:0]       vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             bright,
    output logic             pix_en,
    output logic             frame_start,
    output logic [LED_W-1:0] leds_frame
);

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_SYNC + H_BP + H_ACT + H_FP - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_SYNC + V_BP + V_ACT + V_FP - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_START = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_SYNC + H_BP + H_ACT);
    localparam logic [CNT_W-1:0] V_START = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_SYNC + V_BP + V_ACT);

    logic [CNT_W-1:0] h_nxt;
    logic [CNT_W-1:0] v_nxt;
    logic             wrap_origin;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_en (pix_en)
    );

    always_comb begin
        h_nxt = hcount;
        v_nxt = vcount;
        if (pix_en) begin
            if (hcount == H_LAST) begin
                h_nxt = '0;
                v_nxt = (vcount == V_LAST) ? '0 : vcount + 1'b1;
            end else begin
                h_nxt = hcount + 1'b1;
            end
        end
    end

    // True only on the pixel edge that lands on (0,0); the reset state is
    // already (0,0) but is not reached by a wrap, so the first frame after
    // reset gets no frame_start and keeps leds_frame at zero.
    assign wrap_origin = pix_en && (h_nxt == '0) && (v_nxt == '0);

    // Syncs and bright decode the next counter values so they change on the
    // same clk as hcount/vcount.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            bright      <= 1'b0;
            frame_start <= 1'b0;
            leds_frame  <= '0;
        end else begin
            hcount <= h_nxt;
            vcount <= v_nxt;
            hsync  <= (h_nxt >= H_SYNC_C);
            vsync  <= (v_nxt >= V_SYNC_C);
            bright <= (h_nxt >= H_START) && (h_nxt < H_END) &&
                      (v_nxt >= V_START) && (v_nxt < V_END);
            // frame_start only changes on pixel edges, so it lasts one pixel.
            if (pix_en) begin
                frame_start <= wrap_origin;
            end
            if (wrap_origin) begin
                leds_frame <= leds_in;
            end
        end
    end

endmodule
